// File: rtl/chip1_tinyml.sv
// chip1_tinyml: registered multiply-accumulate, y <= a*b + c, with optional
// two's complement operands and saturating or wrapping overflow.

// One partial-product row of the shift-and-add array: the (sign-extended)
// multiplicand shifted into place, gated by one multiplier bit. The row that
// carries the multiplier's sign bit has negative weight in signed mode.
module chip1_tinyml_pp_row #(
  parameter int P_W   = 16,
  parameter int SHIFT = 0,
  parameter bit NEG   = 1'b0
) (
  input  logic [P_W-1:0] a_ext,
  input  logic           b_bit,
  output logic [P_W-1:0] row
);
  logic [P_W-1:0] shifted;

  // Gate the shifted multiplicand; the sign row subtracts instead of adding.
  always_comb begin
    shifted = a_ext << SHIFT;
    row     = '0;
    if (b_bit) row = NEG ? -shifted : shifted;
  end
endmodule

module chip1_tinyml #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 16,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [ACC_W-1:0] c,
  output logic [ACC_W-1:0] y
);
  localparam int P_W = A_W + B_W;   // full product width
  localparam int S_W = ACC_W + 1;   // sum width, one guard bit for overflow

  logic                      a_sx;
  logic [P_W-1:0]            a_ext;
  logic [B_W-1:0][P_W-1:0]   pp;
  logic [P_W-1:0]            prod;
  logic [S_W-1:0]            p_ext;
  logic [S_W-1:0]            c_ext;
  logic [S_W-1:0]            s;
  logic [ACC_W-1:0]          y_d;
  logic [ACC_W-1:0]          y_q;

  // Multiplicand widened to product width; the product is taken modulo 2^P_W,
  // which is exact because a signed A_W x B_W product always fits in P_W bits.
  always_comb begin
    a_sx  = (SIGNED != 0) && a[A_W-1];
    a_ext = {{B_W{a_sx}}, a};
  end

  for (genvar i = 0; i < B_W; i++) begin : g_row
    chip1_tinyml_pp_row #(
      .P_W  (P_W),
      .SHIFT(i),
      .NEG  ((SIGNED != 0) && (i == B_W - 1))
    ) u_row (
      .a_ext(a_ext),
      .b_bit(b[i]),
      .row  (pp[i])
    );
  end

  // Reduce the partial-product rows and add c with one guard bit.
  always_comb begin
    prod = '0;
    for (int i = 0; i < B_W; i++) prod = prod + pp[i];
    p_ext = {{(S_W - P_W){(SIGNED != 0) && prod[P_W-1]}}, prod};
    c_ext = {(SIGNED != 0) && c[ACC_W-1], c};
    s     = p_ext + c_ext;
  end

  // Overflow handling: a set guard bit means unsigned overflow; differing
  // top two bits mean signed overflow, with the guard bit giving direction.
  always_comb begin
    y_d = s[ACC_W-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (s[ACC_W] != s[ACC_W-1])
          y_d = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else if (s[ACC_W]) begin
        y_d = '1;
      end
    end
  end

  // Result register; reset wins over any operands present that cycle.
  always_ff @(posedge clk) begin
    if (reset) y_q <= '0;
    else       y_q <= y_d;
  end

  assign y = y_q;
endmodule

// File: tb/tb_chip1_tinyml.sv
// Self-checking bench for chip1_tinyml: four instances cover every
// SIGNED/SATURATE combination on shared operands, driven by a directed
// vector table and then by random vectors checked against an integer model.
module tb_chip1_tinyml;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a, b;
  logic [15:0] c;
  logic [15:0] y_us, y_uw, y_ss, y_sw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chip1_tinyml #(.SIGNED(0), .SATURATE(1)) u_us (.clk(clk), .reset(reset), .a(a), .b(b), .c(c), .y(y_us));
  chip1_tinyml #(.SIGNED(0), .SATURATE(0)) u_uw (.clk(clk), .reset(reset), .a(a), .b(b), .c(c), .y(y_uw));
  chip1_tinyml #(.SIGNED(1), .SATURATE(1)) u_ss (.clk(clk), .reset(reset), .a(a), .b(b), .c(c), .y(y_ss));
  chip1_tinyml #(.SIGNED(1), .SATURATE(0)) u_sw (.clk(clk), .reset(reset), .a(a), .b(b), .c(c), .y(y_sw));

  typedef struct {
    bit          rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic [15:0] e_us;
    logic [15:0] e_uw;
    logic [15:0] e_ss;
    logic [15:0] e_sw;
  } vec_t;

  // Plain-integer reference: exact sum, then clamp to the result range.
  function automatic logic [15:0] ref_mac(bit sgn, bit sat, logic [7:0] ai,
                                          logic [7:0] bi, logic [15:0] ci);
    longint sa, sb, sc, s, lo, hi;
    if (sgn) begin
      sa = $signed(ai); sb = $signed(bi); sc = $signed(ci);
      lo = -32768; hi = 32767;
    end else begin
      sa = longint'(ai); sb = longint'(bi); sc = longint'(ci);
      lo = 0; hi = 65535;
    end
    s = sa * sb + sc;
    if (sat) begin
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
    end
    return s[15:0];
  endfunction

  task automatic chk(string nm, int idx, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s idx=%0d got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  // Drive one operand set away from the edge, then sample 1 time unit after.
  task automatic step(bit r, logic [7:0] ai, logic [7:0] bi, logic [15:0] ci);
    @(negedge clk);
    reset = r; a = ai; b = bi; c = ci;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    reset = 1'b1; a = '0; b = '0; c = '0;

    //           rst a      b      c         us       uw       ss       sw
    tbl[0]  = '{1, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{1, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[2]  = '{0, 8'd3,  8'd4,  16'd5,    16'h0011, 16'h0011, 16'h0011, 16'h0011};
    tbl[3]  = '{0, 8'd10, 8'd10, 16'd50,   16'h0096, 16'h0096, 16'h0096, 16'h0096};
    tbl[4]  = '{0, 8'd2,  8'd5,  16'd7,    16'h0011, 16'h0011, 16'h0011, 16'h0011};
    tbl[5]  = '{0, 8'hFF, 8'hFF, 16'd1000, 16'hFFFF, 16'h01E9, 16'h03E9, 16'h03E9};
    tbl[6]  = '{0, 8'hFF, 8'hFF, 16'd510,  16'hFFFF, 16'hFFFF, 16'h01FF, 16'h01FF};
    tbl[7]  = '{0, 8'd0,  8'd200,16'd1234, 16'h04D2, 16'h04D2, 16'h04D2, 16'h04D2};
    tbl[8]  = '{0, 8'hFD, 8'd4,  16'd5,    16'h03F9, 16'h03F9, 16'hFFF9, 16'hFFF9};
    tbl[9]  = '{0, 8'h80, 8'h80, 16'h7FFF, 16'hBFFF, 16'hBFFF, 16'h7FFF, 16'hBFFF};
    tbl[10] = '{0, 8'h80, 8'h7F, 16'h8000, 16'hBF80, 16'hBF80, 16'h8000, 16'h4080};
    tbl[11] = '{1, 8'hFF, 8'hFF, 16'd1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[12] = '{0, 8'd1,  8'd1,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};

    // Directed vectors on consecutive cycles: each result lands one edge later.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].c);
      chk("dir_us", i, y_us, tbl[i].e_us);
      chk("dir_uw", i, y_uw, tbl[i].e_uw);
      chk("dir_ss", i, y_ss, tbl[i].e_ss);
      chk("dir_sw", i, y_sw, tbl[i].e_sw);
    end

    // Hold: with no edge, the result must not move when operands change.
    @(negedge clk);
    a = 8'd7; b = 8'd9; c = 16'd1;
    #2;
    chk("hold_us", 0, y_us, 16'hFFFF);
    chk("hold_uw", 0, y_uw, 16'h0000);

    // Mid-stream reset: one reset edge clears, the next edge resumes at once.
    step(1'b0, 8'd200, 8'd100, 16'd300);
    chk("pre_rst", 0, y_us, 16'd20300);
    step(1'b1, 8'd200, 8'd100, 16'd300);
    chk("mid_rst_us", 0, y_us, 16'h0000);
    chk("mid_rst_ss", 0, y_ss, 16'h0000);
    step(1'b0, 8'd6, 8'd7, 16'd8);
    chk("post_rst_us", 0, y_us, 16'd50);
    chk("post_rst_ss", 0, y_ss, 16'd50);

    // Random stream with occasional resets and biased corner operands.
    for (int n = 0; n < 10000; n++) begin
      logic [7:0]  ra, rb;
      logic [15:0] rc;
      bit          rr;
      rr = ($urandom_range(0, 31) == 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       rc = 16'hFFFF;
        1:       rc = 16'h7FFF;
        2:       rc = 16'h8000;
        3:       rc = 16'h0000;
        default: rc = 16'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) ra = 8'h80;
      if ($urandom_range(0, 15) == 0) rb = 8'hFF;
      step(rr, ra, rb, rc);
      chk("rnd_us", n, y_us, rr ? 16'h0000 : ref_mac(1'b0, 1'b1, ra, rb, rc));
      chk("rnd_uw", n, y_uw, rr ? 16'h0000 : ref_mac(1'b0, 1'b0, ra, rb, rc));
      chk("rnd_ss", n, y_ss, rr ? 16'h0000 : ref_mac(1'b1, 1'b1, ra, rb, rc));
      chk("rnd_sw", n, y_sw, rr ? 16'h0000 : ref_mac(1'b1, 1'b0, ra, rb, rc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
